// File: rtl/sd_block_responder.sv
// Target-side responder for SD sector requests: moves one 512-byte sector
// between a byte-wide backing store and the requester's sector buffer.
module sd_block_responder #(
    parameter int unsigned ACK_DELAY   = 4,
    parameter logic [31:0] IMG_SECTORS = 32'd16384
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [7:0]  sd_buff_din,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE, S_DELAY, S_RD_REQ, S_RD_WAIT, S_RD_PUT,
        S_WR_ADDR, S_WR_CAP, S_WR_WAIT, S_DONE
    } state_t;

    localparam logic [7:0] ACK_CNT = 8'(ACK_DELAY);

    state_t      r_state, w_state_nxt;
    logic [8:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [22:0] r_lba, w_lba_nxt;
    logic        r_dir_rd, w_dir_rd_nxt;
    logic        r_armed, w_armed_nxt;
    logic        r_err, w_err_nxt;
    logic        r_ack, w_ack_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_buff_wr, w_buff_wr_nxt;
    logic [8:0]  r_buff_addr, w_buff_addr_nxt;
    logic [7:0]  r_buff_dout, w_buff_dout_nxt;
    logic        r_mem_rd, w_mem_rd_nxt;
    logic        r_mem_wr, w_mem_wr_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;

    // Next-state and next-output computation; outputs take their value on state entry
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_lba_nxt       = r_lba;
        w_dir_rd_nxt    = r_dir_rd;
        w_err_nxt       = r_err;
        w_ack_nxt       = r_ack;
        w_buff_wr_nxt   = 1'b0;
        w_buff_addr_nxt = r_buff_addr;
        w_buff_dout_nxt = r_buff_dout;
        w_mem_rd_nxt    = 1'b0;
        w_mem_wr_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        if (!sd_rd && !sd_wr) begin
            w_armed_nxt = 1'b1;
        end else begin
            w_armed_nxt = r_armed;
        end

        case (r_state)
            S_IDLE: begin
                if (r_armed && (sd_rd || sd_wr)) begin
                    w_lba_nxt    = sd_lba[22:0];
                    w_dir_rd_nxt = sd_rd;
                    w_err_nxt    = (sd_lba >= IMG_SECTORS);
                    w_idx_nxt    = 9'd0;
                    w_cnt_nxt    = 8'd0;
                    w_state_nxt  = S_DELAY;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_DELAY: begin
                if (r_cnt == ACK_CNT) begin
                    w_ack_nxt = 1'b1;
                    if (r_dir_rd) begin
                        w_state_nxt    = S_RD_REQ;
                        w_mem_rd_nxt   = ~r_err;
                        w_mem_addr_nxt = {r_lba, 9'd0};
                    end else begin
                        w_state_nxt     = S_WR_ADDR;
                        w_buff_addr_nxt = 9'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RD_REQ: begin
                // Out-of-range sectors read as erased flash without touching memory
                if (r_err) begin
                    w_state_nxt     = S_RD_PUT;
                    w_buff_wr_nxt   = 1'b1;
                    w_buff_addr_nxt = r_idx;
                    w_buff_dout_nxt = 8'hFF;
                end else begin
                    w_state_nxt     = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt     = S_RD_PUT;
                    w_buff_wr_nxt   = 1'b1;
                    w_buff_addr_nxt = r_idx;
                    w_buff_dout_nxt = mem_rdata;
                end else begin
                    w_state_nxt     = S_RD_WAIT;
                end
            end
            S_RD_PUT: begin
                if (r_idx == 9'd511) begin
                    w_state_nxt    = S_DONE;
                    w_ack_nxt      = 1'b0;
                end else begin
                    w_idx_nxt      = r_idx + 9'd1;
                    w_state_nxt    = S_RD_REQ;
                    w_mem_rd_nxt   = ~r_err;
                    w_mem_addr_nxt = {r_lba, r_idx + 9'd1};
                end
            end
            S_WR_ADDR: begin
                w_state_nxt    = S_WR_CAP;
                w_mem_wr_nxt   = ~r_err;
                w_mem_addr_nxt = {r_lba, r_idx};
            end
            S_WR_CAP: begin
                w_mem_wdata_nxt = sd_buff_din;
                if (!r_err) begin
                    w_state_nxt     = S_WR_WAIT;
                end else if (r_idx == 9'd511) begin
                    w_state_nxt     = S_DONE;
                    w_ack_nxt       = 1'b0;
                end else begin
                    w_idx_nxt       = r_idx + 9'd1;
                    w_state_nxt     = S_WR_ADDR;
                    w_buff_addr_nxt = r_idx + 9'd1;
                end
            end
            S_WR_WAIT: begin
                if (!mem_ready) begin
                    w_state_nxt     = S_WR_WAIT;
                end else if (r_idx == 9'd511) begin
                    w_state_nxt     = S_DONE;
                    w_ack_nxt       = 1'b0;
                end else begin
                    w_idx_nxt       = r_idx + 9'd1;
                    w_state_nxt     = S_WR_ADDR;
                    w_buff_addr_nxt = r_idx + 9'd1;
                end
            end
            S_DONE: begin
                w_armed_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ack_nxt   = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 9'd0;
            r_cnt       <= 8'd0;
            r_lba       <= 23'd0;
            r_dir_rd    <= 1'b0;
            r_armed     <= 1'b0;
            r_err       <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_buff_wr   <= 1'b0;
            r_buff_addr <= 9'd0;
            r_buff_dout <= 8'd0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lba       <= w_lba_nxt;
            r_dir_rd    <= w_dir_rd_nxt;
            r_armed     <= w_armed_nxt;
            r_err       <= w_err_nxt;
            r_ack       <= w_ack_nxt;
            r_busy      <= w_busy_nxt;
            r_buff_wr   <= w_buff_wr_nxt;
            r_buff_addr <= w_buff_addr_nxt;
            r_buff_dout <= w_buff_dout_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // The buffer byte is only valid during WR_CAP, so it is forwarded with the write pulse
    assign mem_wdata    = (r_state == S_WR_CAP) ? sd_buff_din : r_mem_wdata;
    assign sd_ack       = r_ack;
    assign sd_buff_addr = r_buff_addr;
    assign sd_buff_dout = r_buff_dout;
    assign sd_buff_wr   = r_buff_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_rd       = r_mem_rd;
    assign mem_wr       = r_mem_wr;
    assign busy         = r_busy;
    assign err          = r_err;

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder: memory/buffer models plus a
// sector-level reference of the backing store.
module tb_sd_block_responder;

    localparam int          ACKD = 4;
    localparam logic [31:0] IMG  = 32'd16384;

    logic        clk_sys, reset_n, sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic        mem_rd, mem_wr, mem_ready, busy, err;
    logic [31:0] sd_lba, mem_addr;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din, mem_wdata, mem_rdata;

    sd_block_responder #(.ACK_DELAY(ACKD), .IMG_SECTORS(IMG)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0, ack_cnt, rd_cnt, wr_cnt, strobe_cnt, order_bad, spacing_bad;
    int last_strobe, busy_rises, busy_rise_cyc, ack_rise_cyc, wait_sum, addr_unstable;
    logic        prev_busy = 1'b0, prev_ack = 1'b0, lat_rand = 1'b0;
    logic [31:0] first_rd_addr;
    logic [7:0]  rbuf [512];
    logic [7:0]  bufmem [512];
    logic [31:0] waddr_q [$];
    logic [7:0]  wdata_q [$];
    logic [7:0]  wmem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        else return a[7:0] ^ 8'h5A;
    endfunction

    task automatic clr();
        ack_cnt = 0; rd_cnt = 0; wr_cnt = 0; strobe_cnt = 0; order_bad = 0;
        spacing_bad = 0; busy_rises = 0; wait_sum = 0; addr_unstable = 0;
        busy_rise_cyc = 0; ack_rise_cyc = 0; last_strobe = 0; first_rd_addr = 32'd0;
        waddr_q.delete(); wdata_q.delete();
        for (int i = 0; i < 512; i++) rbuf[i] = 8'hxx;
    endtask

    // Registered requester buffer: data follows the address by one cycle
    initial begin
        logic [8:0] ba;
        sd_buff_din = 8'd0;
        forever begin
            @(negedge clk_sys); ba = sd_buff_addr;
            @(posedge clk_sys); #1; sd_buff_din = bufmem[ba];
        end
    end

    // Backing store: answers each pulse after 1 (or 1..7 random) cycles
    initial begin
        logic [31:0] a;
        int d;
        mem_ready = 1'b0; mem_rdata = 8'd0;
        forever begin
            @(posedge clk_sys); #2;
            if (reset_n && (mem_rd || mem_wr)) begin
                a = mem_addr;
                if (mem_wr) wmem[a] = mem_wdata;
                d = lat_rand ? int'($urandom_range(7, 1)) : 1;
                wait_sum += d;
                for (int k = 0; k < d; k++) begin
                    @(posedge clk_sys); #2;
                    if (reset_n && mem_addr !== a) addr_unstable++;
                end
                mem_rdata = wmem.exists(a) ? wmem[a] : (a[7:0] ^ 8'h5A);
                mem_ready = 1'b1;
                @(posedge clk_sys); #2;
                mem_ready = 1'b0;
            end
        end
    end

    // Bus monitor sampling on the falling edge
    initial begin
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (sd_ack) ack_cnt++;
            if (mem_rd) begin
                if (rd_cnt == 0) first_rd_addr = mem_addr;
                rd_cnt++;
            end
            if (mem_wr) begin
                waddr_q.push_back(mem_addr); wdata_q.push_back(mem_wdata); wr_cnt++;
            end
            if (sd_buff_wr) begin
                if (int'(sd_buff_addr) != strobe_cnt) order_bad++;
                if (strobe_cnt > 0 && cyc - last_strobe < 3) spacing_bad++;
                last_strobe = cyc;
                rbuf[sd_buff_addr] = sd_buff_dout;
                strobe_cnt++;
            end
            if (busy && !prev_busy) begin busy_rises++; busy_rise_cyc = cyc; end
            if (sd_ack && !prev_ack) ack_rise_cyc = cyc;
            prev_busy = busy; prev_ack = sd_ack;
        end
    end

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] lba, input logic hold);
        clr();
        @(negedge clk_sys); sd_lba = lba; sd_rd = rd; sd_wr = wr;
        for (int k = 0; k < 20 && !busy; k++) @(negedge clk_sys);
        chk("accept_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 300 && !sd_ack; k++) @(negedge clk_sys);
        chk("ack_rise", 32'(sd_ack), 32'd1);
        if (!hold) begin sd_rd = 1'b0; sd_wr = 1'b0; end
        for (int k = 0; k < 8000 && busy; k++) @(negedge clk_sys);
        chk("xfer_end", 32'(busy), 32'd0);
        #1;
    endtask

    task automatic chk_read(input logic [31:0] lba, input logic oor);
        int bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (rbuf[i] !== (oor ? 8'hFF : exp_byte({lba[22:0], 9'(i)}))) bad++;
        end
        chk("rd_data_bad", 32'(bad), 32'd0);
        chk("rd_strobes", 32'(strobe_cnt), 32'd512);
        chk("rd_order_bad", 32'(order_bad), 32'd0);
        chk("rd_mem_pulses", 32'(rd_cnt), oor ? 32'd0 : 32'd512);
        chk("rd_err", 32'(err), 32'(oor));
    endtask

    task automatic chk_write(input logic [31:0] lba);
        int bad = 0;
        logic [31:0] ea;
        chk("wr_pulses", 32'(wr_cnt), 32'd512);
        for (int i = 0; i < 512; i++) begin
            ea = {lba[22:0], 9'(i)};
            if (i >= waddr_q.size() || waddr_q[i] !== ea || wdata_q[i] !== bufmem[i]) bad++;
            ref_mem[ea] = bufmem[i];
        end
        chk("wr_addr_data_bad", 32'(bad), 32'd0);
        chk("wr_err", 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] rl;
        sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = 32'd0; reset_n = 1'b0;
        for (int i = 0; i < 512; i++) bufmem[i] = 8'(i);
        clr();
        repeat (3) @(negedge clk_sys);
        chk("rst_ack", 32'(sd_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", {29'd0, sd_buff_wr, mem_rd, mem_wr}, 32'd0);
        chk("rst_buff", {15'd0, sd_buff_addr, sd_buff_dout}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // Request already high when reset releases: must not be accepted
        sd_rd = 1'b1;
        @(negedge clk_sys); reset_n = 1'b1;
        repeat (6) @(negedge clk_sys);
        chk("unarmed_no_accept", 32'(busy_rises), 32'd0);
        sd_rd = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Read LBA 5, one-cycle memory
        xfer(1'b1, 1'b0, 32'd5, 1'b0);
        chk("ack_delay", 32'(ack_rise_cyc - busy_rise_cyc), 32'(ACKD + 1));
        chk("first_mem_addr", first_rd_addr, 32'h0000_0A00);
        chk("rd_ack_cycles", 32'(ack_cnt), 32'd1536);
        chk("rd_spacing_bad", 32'(spacing_bad), 32'd0);
        chk_read(32'd5, 1'b0);

        // Write LBA 2 with idx pattern, then read it back
        xfer(1'b0, 1'b1, 32'd2, 1'b0);
        chk("wr_ack_cycles", 32'(ack_cnt), 32'd1536);
        chk("wr_first_addr", (waddr_q.size() > 0) ? waddr_q[0] : 32'hDEAD_BEEF, 32'h0000_0400);
        chk_write(32'd2);
        xfer(1'b1, 1'b0, 32'd2, 1'b0);
        chk_read(32'd2, 1'b0);

        // Out-of-range read, then last valid sector clears err
        xfer(1'b1, 1'b0, IMG, 1'b0);
        chk("oor_rd_ack_cycles", 32'(ack_cnt), 32'd1024);
        chk_read(IMG, 1'b1);
        xfer(1'b1, 1'b0, IMG - 32'd1, 1'b0);
        chk_read(IMG - 32'd1, 1'b0);

        // Level request held through DONE does not retrigger
        xfer(1'b1, 1'b0, 32'd7, 1'b1);
        repeat (20) @(negedge clk_sys);
        #1;
        chk("hold_single_xfer", 32'(busy_rises), 32'd1);
        chk("hold_idle", 32'(busy), 32'd0);
        sd_rd = 1'b0;
        @(negedge clk_sys);
        xfer(1'b1, 1'b0, 32'd8, 1'b0);
        chk_read(32'd8, 1'b0);

        // Both lines high: read wins
        xfer(1'b1, 1'b1, 32'd9, 1'b0);
        chk("both_no_mem_wr", 32'(wr_cnt), 32'd0);
        chk_read(32'd9, 1'b0);

        // Random memory latency: write random data then read it back
        lat_rand = 1'b1;
        rl = 32'($urandom_range(int'(IMG) - 1, 0));
        for (int i = 0; i < 512; i++) bufmem[i] = 8'($urandom);
        xfer(1'b0, 1'b1, rl, 1'b0);
        chk("rand_wr_ack_cycles", 32'(ack_cnt), 32'(1024 + wait_sum));
        chk("rand_wr_addr_stable", 32'(addr_unstable), 32'd0);
        chk_write(rl);
        xfer(1'b1, 1'b0, rl, 1'b0);
        chk("rand_rd_ack_cycles", 32'(ack_cnt), 32'(1024 + wait_sum));
        chk("rand_rd_addr_stable", 32'(addr_unstable), 32'd0);
        chk_read(rl, 1'b0);
        lat_rand = 1'b0;

        // Out-of-range write at the top of the LBA space
        xfer(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("oor_wr_pulses", 32'(wr_cnt), 32'd0);
        chk("oor_wr_ack_cycles", 32'(ack_cnt), 32'd1024);
        chk("oor_wr_err", 32'(err), 32'd1);

        // Reset asserted at idx 100 of a read
        clr();
        @(negedge clk_sys); sd_lba = 32'd3; sd_rd = 1'b1;
        for (int k = 0; k < 3000 && strobe_cnt < 100; k++) begin @(negedge clk_sys); #1; end
        chk("reached_idx100", 32'(strobe_cnt), 32'd100);
        #1; reset_n = 1'b0; #1;
        chk("midrst_ack_busy", {30'd0, sd_ack, busy}, 32'd0);
        chk("midrst_strobes", {29'd0, sd_buff_wr, mem_rd, mem_wr}, 32'd0);
        chk("midrst_buff", {15'd0, sd_buff_addr, sd_buff_dout}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        clr();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (6) @(negedge clk_sys);
        #1;
        chk("midrst_quiet", 32'(strobe_cnt + busy_rises), 32'd0);
        sd_rd = 1'b0;
        @(negedge clk_sys);
        xfer(1'b1, 1'b0, 32'd3, 1'b0);
        chk_read(32'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
